// File: rtl/video_timing_gen_pkg.sv
// ============================================================================
// video_timing_gen_pkg: default 640x480@60 timing, total derivation, bar colours
// Revision 1.0
// ============================================================================
`default_nettype none

package video_timing_gen_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int CNT_W = 12;

  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  // Colour bars left to right: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [23:0] bar_rgb(logic [2:0] idx);
    logic [23:0] rgb;
    rgb = 24'h000000;
    case (idx)
      3'd0: rgb = 24'hFFFFFF;
      3'd1: rgb = 24'hFFFF00;
      3'd2: rgb = 24'h00FFFF;
      3'd3: rgb = 24'h00FF00;
      3'd4: rgb = 24'hFF00FF;
      3'd5: rgb = 24'hFF0000;
      3'd6: rgb = 24'h0000FF;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_timing_gen_axis_counter.sv
// ============================================================================
// video_axis_counter: one raster axis -- wrapping counter with sync/active decode
// Revision 1.0
// ============================================================================
`default_nettype none

module video_axis_counter
  import video_timing_gen_pkg::*;
#(
  parameter int   ACTIVE = 640,
  parameter int   FP     = 16,
  parameter int   SYNC   = 96,
  parameter int   BP     = 48,
  parameter logic POL    = 1'b1
) (
  input  logic             clkI,
  input  logic             rstI,
  input  logic             enI,
  output logic [CNT_W-1:0] cntO,
  output logic             wrapO,
  output logic             syncO,
  output logic             activeO
);

  localparam int               TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  // One extra bit so a TOTAL of 4096 cannot alias the decode bounds to zero
  localparam logic [CNT_W:0]   SYNC_LO = (CNT_W+1)'(ACTIVE + FP);
  localparam logic [CNT_W:0]   SYNC_HI = (CNT_W+1)'(ACTIVE + FP + SYNC);
  localparam logic [CNT_W:0]   ACT_HI  = (CNT_W+1)'(ACTIVE);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   cnt_ext;
  logic             at_last;

  assign at_last = (cnt_q == LAST);
  assign wrapO   = enI && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (enI) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_ext = {1'b0, cnt_q};
  assign cntO    = cnt_q;
  assign syncO   = ((cnt_ext >= SYNC_LO) && (cnt_ext < SYNC_HI)) ? POL : ~POL;
  assign activeO = (cnt_ext < ACT_HI);

endmodule

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
// video_timing_gen: registered raster timing; define TEST_PATTERN_EN for colour bars
// Revision 1.0
// ============================================================================
`default_nettype none

module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        pixclkI,
  input  logic        rstI,
  output logic        hSyncO,
  output logic        vSyncO,
  output logic        DrawAreaO,
  output logic [11:0] xO,
  output logic [11:0] yO,
  output logic        lineStartO,
  output logic        frameStartO,
  output logic [7:0]  redO,
  output logic [7:0]  greenO,
  output logic [7:0]  blueO
);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap_unused;
  logic             h_sync;
  logic             v_sync;
  logic             h_act;
  logic             v_act;
  logic             draw;
  logic             h_zero;

  video_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL)
  ) u_h_axis (
    .clkI    (pixclkI),
    .rstI    (rstI),
    .enI     (1'b1),
    .cntO    (h_cnt),
    .wrapO   (h_wrap),
    .syncO   (h_sync),
    .activeO (h_act)
  );

  // Vertical advances only on the horizontal wrap, so its sync edges are line-aligned
  video_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL)
  ) u_v_axis (
    .clkI    (pixclkI),
    .rstI    (rstI),
    .enI     (h_wrap),
    .cntO    (v_cnt),
    .wrapO   (v_wrap_unused),
    .syncO   (v_sync),
    .activeO (v_act)
  );

  assign draw   = h_act && v_act;
  assign h_zero = (h_cnt == '0);

  logic        hsync_q;
  logic        vsync_q;
  logic        draw_q;
  logic [11:0] x_q;
  logic [11:0] y_q;
  logic        line_start_q;
  logic        frame_start_q;

  always_ff @(posedge pixclkI or posedge rstI) begin
    if (rstI) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      draw_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= h_sync;
      vsync_q       <= v_sync;
      draw_q        <= draw;
      x_q           <= h_cnt;
      y_q           <= v_cnt;
      line_start_q  <= h_zero;
      frame_start_q <= h_zero && (v_cnt == '0);
    end
  end

  assign hSyncO      = hsync_q;
  assign vSyncO      = vsync_q;
  assign DrawAreaO   = draw_q;
  assign xO          = x_q;
  assign yO          = y_q;
  assign lineStartO  = line_start_q;
  assign frameStartO = frame_start_q;

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  // pix_q/bar_q track h_cnt: both return to 0 on the same edge h_cnt does
  logic [CNT_W-1:0] pix_q;
  logic [CNT_W-1:0] pix_d;
  logic [2:0]       bar_q;
  logic [2:0]       bar_d;
  logic [23:0]      rgb_q;

  always_comb begin
    pix_d = pix_q + 1'b1;
    bar_d = bar_q;
    if (h_wrap) begin
      pix_d = '0;
      bar_d = '0;
    end else if (pix_q == CNT_W'(BAR_W - 1)) begin
      pix_d = '0;
      bar_d = bar_q + 1'b1;
    end
  end

  always_ff @(posedge pixclkI or posedge rstI) begin
    if (rstI) begin
      pix_q <= '0;
      bar_q <= '0;
      rgb_q <= '0;
    end else begin
      pix_q <= pix_d;
      bar_q <= bar_d;
      rgb_q <= draw ? bar_rgb(bar_q) : 24'h000000;
    end
  end

  assign redO   = rgb_q[23:16];
  assign greenO = rgb_q[15:8];
  assign blueO  = rgb_q[7:0];
`else
  assign redO   = 8'h00;
  assign greenO = 8'h00;
  assign blueO  = 8'h00;
`endif

endmodule

`default_nettype wire

// File: doc/video_timing_gen.md
# video_timing_gen

Generates raster timing for the HDMI output path: horizontal/vertical counters, sync pulses, active-area flag, pixel coordinates and frame/line start strobes, all registered on the pixel clock. Its hSyncO/vSyncO/DrawAreaO drive the TMDS encoder/serializer stage directly, and its xO/yO feed whatever pixel source produces red/green/blue. Sync, DrawArea, coordinates and optional test-pattern colour leave on the same clock edge, so they are mutually aligned.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 1'b1, asserted level of hSyncO
- VS_POL, 1'b1, asserted level of vSyncO
- pixclkI  input  1  pixel clock; the only clock
- rstI  input  1  reset; asynchronous, active-high
- hSyncO  output  1  horizontal sync
- vSyncO  output  1  vertical sync
- DrawAreaO  output  1  high during visible pixels
- xO  output  12  horizontal counter value (0..H_TOTAL-1)
- yO  output  12  vertical counter value (0..V_TOTAL-1)
- lineStartO  output  1  one-cycle strobe at x=0 of every line
- frameStartO  output  1  one-cycle strobe at x=0, y=0
- redO, greenO, blueO  output  8 each  test-pattern colour (see Configuration)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; both must be ≤ 4096 (12-bit counters, no overflow path).
- hCount increments every cycle, wraps H_TOTAL-1 → 0; on wrap vCount increments, wrapping V_TOTAL-1 → 0.
- Combinational decode from (hCount, vCount), registered into outputs:
  - hSync asserted iff H_ACTIVE+H_FP ≤ hCount < H_ACTIVE+H_FP+H_SYNC; deasserted level = ~HS_POL.
  - vSync asserted iff V_ACTIVE+V_FP ≤ vCount < V_ACTIVE+V_FP+V_SYNC; vSync edges occur at hCount=0 (line-aligned).
  - DrawArea = (hCount < H_ACTIVE) && (vCount < V_ACTIVE).
  - lineStart = (hCount==0); frameStart = (hCount==0 && vCount==0).
- xO/yO are the registered counter values, valid in blanking too; consumers gate with DrawAreaO.

## Timing
- Reset (async assert, any time incl. mid-line): hCount=vCount=0; hSyncO=~HS_POL, vSyncO=~VS_POL, DrawAreaO=0, xO=yO=0, lineStartO=frameStartO=0, RGB=0.
- Output latency: one cycle from counter state to outputs. First edge after reset release presents state (0,0): DrawAreaO=1, lineStartO=frameStartO=1, xO=yO=0.
- Counters advance on the first edge after reset release; no dead cycle.
- frameStartO period exactly H_TOTAL*V_TOTAL cycles; lineStartO period exactly H_TOTAL.
- Last active pixel (H_ACTIVE-1, V_ACTIVE-1) followed next cycle by DrawAreaO=0.
- Simultaneous h-wrap and v-wrap: both counters return to 0 on the same edge; frameStartO fires on the following output cycle.

## Configuration
- TEST_PATTERN_EN defined: redO/greenO/blueO carry 8 vertical colour bars, each BAR_W = H_ACTIVE/8 pixels wide, order white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF/8'h00). Bar index from a 3-bit counter reset at hCount=0 and incremented each BAR_W pixels; colour registered with the syncs, forced 0 outside DrawArea.
- Not defined: RGB ports present, driven constant 0; bar counter absent.

## Structure
- Shared package: default 640x480@60 timing constants, H_TOTAL/V_TOTAL derivation, 8-entry colour-bar RGB lookup.
- One sub-module, video_axis_counter (parameters ACTIVE, FP, SYNC, BP, POL): count with wrap, wrap-out strobe, sync/active decode; instantiated for horizontal (enable=1) and vertical (enable=h wrap).

## Test plan
- Assert rstI mid-line at hCount=300 → all outputs at reset values within same cycle; first edge after release shows xO=0, yO=0, frameStartO=1, DrawAreaO=1.
- Default params, run 2 frames → frameStartO interval 420000 cycles, lineStartO interval 800, DrawAreaO high 307200 cycles per frame.
- Line check → hSyncO asserted for xO 656..751 (96 cycles), deasserted elsewhere; vSyncO asserted for yO 490..491, transitions coincident with xO=0.
- HS_POL=VS_POL=0 → sync levels inverted, identical positions; reset value of syncs = 1.
- Small params (H 8/1/2/1, V 4/1/1/1) → counters wrap at 11 and 6; simultaneous wrap yields (0,0) with frameStartO, no skipped or repeated state.
- TEST_PATTERN_EN, default params → RGB at x=0 FFFFFF, x=80 FFFF00, x=639 000000, all zero at x=640 and in vertical blanking.
